// File: rtl/siso_shift_sched_if.sv
// Request/serial-lane bundle for siso_shift_sched: producers drive master, the scheduler sits on slave.
interface siso_shift_sched_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       done;
  logic [IDW-1:0]        gnt_id;
  logic                  sout;
  logic                  shift_en;
  logic                  frame;
  logic                  busy;

  modport master (
    output req, data_in,
    input  ack, done, gnt_id, sout, shift_en, frame, busy
  );

  modport slave (
    input  req, data_in,
    output ack, done, gnt_id, sout, shift_en, frame, busy
  );
endinterface

// File: rtl/siso_shift_sched.sv
// Round-robin scheduler serialising one requester's word LSB-first onto a shared SISO lane.
// Optional SISO_SHIFT_PARITY_EN appends an even-parity bit after the MSB of each frame.
module siso_shift_sched #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic              clk,
  input  logic              reset,
  siso_shift_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
`ifdef SISO_SHIFT_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam int GW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(FLEN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP == 0) ? 0 : GAP - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAPS} state_t;

  state_t          state_q, state_d;
  logic [FLEN-1:0] shreg_q;
  logic [CW-1:0]   cnt_q;
  logic [GW-1:0]   gap_q;
  logic [IDW-1:0]  gnt_q;
  logic [IDW-1:0]  last_q;
  logic [IDW-1:0]  win;
  logic [WIDTH-1:0] word;
  logic [NREQ-1:0] gnt_oh;

  // First asserted request strictly after the previous winner, wrapping around.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    logic           found;
    int             idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && r[idx]) begin
        pick  = IDW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [FLEN-1:0] frame_word(input logic [WIDTH-1:0] w);
`ifdef SISO_SHIFT_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  assign win    = rr_pick(bus.req, last_q);
  assign word   = bus.data_in[int'(win)*WIDTH +: WIDTH];
  assign gnt_oh = NREQ'(1) << gnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = (GAP == 0) ? IDLE : GAPS;
      GAPS:    if (gap_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture on grant, then shift one bit per clock; cnt stops at FLEN so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      last_q  <= IDW'(NREQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            shreg_q <= frame_word(word);
            cnt_q   <= '0;
            gnt_q   <= win;
            last_q  <= win;
          end
        end
        SHIFT: begin
          shreg_q <= shreg_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
          gap_q   <= '0;
        end
        GAPS:    gap_q <= gap_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.sout     = 1'b0;
    bus.shift_en = 1'b0;
    bus.frame    = 1'b0;
    bus.ack      = '0;
    bus.done     = '0;
    bus.busy     = (state_q != IDLE);
    bus.gnt_id   = gnt_q;
    if (state_q == SHIFT) begin
      bus.sout     = shreg_q[0];
      bus.shift_en = 1'b1;
      bus.frame    = 1'b1;
      if (cnt_q == '0)      bus.ack  = gnt_oh;
      if (cnt_q == CNT_LAST) bus.done = gnt_oh;
    end
  end
endmodule
